char_feeder: RTL and testbench
==============================

# char_feeder

Character transmitter for the regex match engines. It buffers host-written strings in a FIFO and streams them one byte per handshake to a downstream matcher (`out_char`/`out_valid`/`out_ready`). It collects the matcher's registered per-character verdict and reports one result per string: whether any character matched, and the index of the first match. It sits between the host/text loader and the `char`-class matcher cells.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `IDX_W`, 8: width of the character index within a string.

Ports:
- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `wr_en`, in, 1: host write strobe.
- `wr_char`, in, 8: byte to enqueue.
- `wr_last`, in, 1: byte is the final character of its string.
- `full`, out, 1: FIFO holds `DEPTH` entries.
- `overflow`, out, 1: sticky; a write was dropped while full.
- `out_char`, out, 8: head character presented to the matcher.
- `out_last`, out, 1: head is the final character of its string.
- `out_index`, out, IDX_W: position of the head within its string, starting at 0.
- `out_valid`, out, 1: head is valid.
- `out_ready`, in, 1: matcher accepts; transfer when `out_valid && out_ready`.
- `match_valid`, in, 1: matcher verdict strobe for the previously accepted character.
- `match_in`, in, 1: verdict (1 = match).
- `result_valid`, out, 1: one-cycle pulse; string finished.
- `result_found`, out, 1: at least one character of the string matched.
- `result_index`, out, IDX_W: `out_index` of the first matching character; 0 if none.

## Operation
- FIFO entries are 9 bits: `{wr_last, wr_char}`. It uses registered output with no fall-through.
- A write when `full` is 1 at the start of the cycle is dropped and sets `overflow`. This holds even if a read happens in the same cycle.
- A simultaneous read and write when not full leaves the count unchanged.
- The FSM has four states: IDLE, STREAM, WAIT, DONE.
  - IDLE: `out_valid`=0. Go to STREAM when the FIFO is non-empty. The index counter is 0.
  - STREAM: `out_valid`=1, showing the FIFO head. On each transfer, pop the FIFO, record `last_idx` = `out_index`, and increment the index.
    - If the transferred entry has `out_last`=1, go to WAIT.
    - If the FIFO is empty after a non-last transfer, stay in STREAM with `out_valid`=0 until data arrives.
  - WAIT: one cycle. `out_valid`=0. Sample the verdict for the last character, then go to DONE.
  - DONE: `result_valid`=1 for exactly one cycle. Clear `found` and the index, then go to IDLE.
- Verdict capture:
  - A verdict is a cycle with `match_valid`=1 while in STREAM or WAIT. It refers to the character transferred in the previous cycle (`last_idx`).
  - On the first verdict with `match_in`=1 in a string, latch `found`=1 and `found_idx`=`last_idx`. Later matches do not change `found_idx`.
  - A `match_valid` in IDLE or DONE is ignored.
- The index counter wraps modulo 2^IDX_W. Strings longer than that alias their indices; this is not flagged.
- `result_found` and `result_index` hold their values until the next DONE.

## Timing
- Values after reset:
  - FIFO empty, state IDLE.
  - `full`=0, `overflow`=0, `out_valid`=0, `out_char`=0, `out_last`=0, `out_index`=0.
  - `result_valid`=0, `result_found`=0, `result_index`=0.
- Reset mid-string flushes the FIFO and discards the partial string's result. No `result_valid` pulse is produced.
- Write-to-output latency: a write at edge N into an empty FIFO gives `out_valid`=1 in the cycle after edge N+1 (state moves from IDLE to STREAM).
- Throughput is one character per cycle with `out_ready` held high.
- `out_char`, `out_last` and `out_index` are stable while `out_valid && !out_ready`.
- Result latency: the last character is transferred at edge T.
  - Its verdict is sampled at edge T+1 (WAIT).
  - `result_valid` is high for the cycle after edge T+2.
  - The next string's first character can be presented after edge T+3.
- `full` and `overflow` are registered and reflect state after the edge.

## Test plan
- Single string "ABA" with `wr_last` on the final 'A', `out_ready`=1, matcher verdicts 1,0,1:
  - `out_index` goes 0,1,2.
  - One `result_valid` pulse with `result_found`=1 and `result_index`=0.
- String "xyz", verdicts all 0 → `result_found`=0, `result_index`=0, exactly one pulse.
- Backpressure: toggle `out_ready` 1,0,0,1 on "QRS".
  - `out_char` holds 'R' through the stalled cycles.
  - No duplicated or skipped characters; the indices are 0,1,2.
- Overflow:
  - Write 17 bytes back-to-back with `DEPTH`=16 and `out_ready`=0 → `full`=1 after 16 writes, the 17th is dropped, `overflow`=1.
  - Drain → 16 characters out, in order.
- Two strings queued back-to-back ("AB"+last, "CA"+last), verdict 1 only on 'A':
  - Two results: (found=1, idx=0) then (found=1, idx=1).
  - The second string's `out_index` restarts at 0.
- Reset asserted mid-stream after index 2 of a 5-character string:
  - All outputs return to their reset values and there is no `result_valid`.
  - A new string then streams from index 0.

Source files
------------

// File: rtl/char_feeder.sv
// char_feeder: buffers host-written strings and streams them one byte per handshake
// to a char-class matcher, reporting per string whether and where it first matched.

module char_feeder_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             wr_ok;
  logic             rd_ok;

  // full is the registered flag, so a pop in the same cycle never rescues a write
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // storage is cleared too so the head output reads zero after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      if (wr_en && full) overflow <= 1'b1;
    end
  end
endmodule

module char_feeder #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [7:0]       wr_char,
  input  logic             wr_last,
  output logic             full,
  output logic             overflow,
  output logic [7:0]       out_char,
  output logic             out_last,
  output logic [IDX_W-1:0] out_index,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             match_valid,
  input  logic             match_in,
  output logic             result_valid,
  output logic             result_found,
  output logic [IDX_W-1:0] result_index
);
  // state  | meaning
  // IDLE   | no string in flight, index at 0, waiting for FIFO data
  // STREAM | presenting FIFO head; out_valid low while the FIFO is empty
  // WAIT   | last char sent; one cycle to catch its registered verdict
  // DONE   | publish the result and clear per-string state
  typedef enum logic [1:0] {IDLE, STREAM, WAIT, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [8:0]       head;
  logic             fifo_empty;
  logic             xfer;
  logic             verdict;
  logic             found;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] found_idx;

  char_feeder_fifo #(.DEPTH(DEPTH), .WIDTH(9)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  ({wr_last, wr_char}),
    .rd_en    (xfer),
    .rd_data  (head),
    .empty    (fifo_empty),
    .full     (full),
    .overflow (overflow)
  );

  assign out_char  = head[7:0];
  assign out_last  = head[8];
  assign out_index = idx;
  assign xfer      = out_valid && out_ready;
  assign verdict   = match_valid && (state == STREAM || state == WAIT);

  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) state_next = STREAM;
      end
      STREAM: begin
        out_valid = !fifo_empty;
        if (!fifo_empty && out_ready && head[8]) state_next = WAIT;
      end
      WAIT:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      last_idx     <= '0;
      found        <= 1'b0;
      found_idx    <= '0;
      result_valid <= 1'b0;
      result_found <= 1'b0;
      result_index <= '0;
    end else begin
      state        <= state_next;
      result_valid <= 1'b0;
      if (xfer) begin
        last_idx <= idx;
        idx      <= idx + IDX_W'(1);
      end
      // verdict always refers to the char accepted one cycle earlier
      if (verdict && match_in && !found) begin
        found     <= 1'b1;
        found_idx <= last_idx;
      end
      if (state == DONE) begin
        result_valid <= 1'b1;
        result_found <= found;
        result_index <= found_idx;
        found        <= 1'b0;
        found_idx    <= '0;
        idx          <= '0;
      end
    end
  end
endmodule

// File: tb/tb_char_feeder.sv
// tb_char_feeder: randomized scenarios for char_feeder checked against a
// string-level model of accepted characters, indices and per-string results.

module tb_char_feeder;
  localparam int DEPTH = 16;
  localparam int IDX_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr_en;
  logic [7:0]       wr_char;
  logic             wr_last;
  logic             full;
  logic             overflow;
  logic [7:0]       out_char;
  logic             out_last;
  logic [IDX_W-1:0] out_index;
  logic             out_valid;
  logic             out_ready;
  logic             match_valid;
  logic             match_in;
  logic             result_valid;
  logic             result_found;
  logic [IDX_W-1:0] result_index;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [7:0] ch;
    logic       last;
    logic [7:0] idx;
  } xfer_t;

  typedef struct packed {
    logic       found;
    logic [7:0] idx;
  } res_t;

  logic [7:0] sc_chars[$];
  bit         sc_last[$];
  bit         rdy_pat[$];

  char_feeder #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_char      (wr_char),
    .wr_last      (wr_last),
    .full         (full),
    .overflow     (overflow),
    .out_char     (out_char),
    .out_last     (out_last),
    .out_index    (out_index),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .match_valid  (match_valid),
    .match_in     (match_in),
    .result_valid (result_valid),
    .result_found (result_found),
    .result_index (result_index)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    wr_en = 1'b0; wr_char = 8'h00; wr_last = 1'b0;
    out_ready = 1'b0; match_valid = 1'b0; match_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic add_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      sc_chars.push_back(s[i]);
      sc_last.push_back(i == s.len() - 1);
    end
  endtask

  // Plays the host and a matcher that answers one cycle after each accepted
  // char with (char == match_ch); every output is compared to the model.
  task automatic run_scenario(input string name, input bit rst, input int ready_pct,
                              input int wr_pct, input int ready_hold, input logic [7:0] match_ch);
    xfer_t exp_q[$];
    res_t  res_q[$];
    int    rt_q[$];
    xfer_t e, ne;
    res_t  r;
    int    occ, wpos, cyc, idle, t;
    bit    ovf, wfound, pv_xfer, pv_stall, rdy, xf;
    logic [7:0] widx, wfidx, pv_ch;
    occ = 0; wpos = 0; cyc = 0; idle = 0; ovf = 0; wfound = 0;
    pv_xfer = 0; pv_stall = 0; widx = 0; wfidx = 0; pv_ch = 0;
    if (rst) do_reset();
    while (cyc < 5000 && idle < 6) begin
      if (result_valid === 1'b1) begin
        tests++;
        if (res_q.size() == 0) begin
          fails++;
          $display("FAIL %s result: unexpected result_valid pulse at cycle %0d", name, cyc);
        end else begin
          r = res_q.pop_front();
          if (result_found !== r.found || result_index !== r.idx) begin
            fails++;
            $display("FAIL %s result: got found=%b idx=%0d, expected found=%b idx=%0d",
                     name, result_found, result_index, r.found, r.idx);
          end
        end
        if (rt_q.size() > 0) begin
          t = rt_q.pop_front();
          tests++;
          if (cyc - t != 3) begin
            fails++;
            $display("FAIL %s result_latency: got %0d cycles, expected 3", name, cyc - t);
          end
        end
      end
      tests++;
      if (full !== (occ == DEPTH)) begin
        fails++;
        $display("FAIL %s full: got %b, expected %b (occupancy %0d)", name, full, occ == DEPTH, occ);
      end
      tests++;
      if (overflow !== ovf) begin
        fails++;
        $display("FAIL %s overflow: got %b, expected %b", name, overflow, ovf);
      end
      if (pv_stall) begin
        tests++;
        if (out_valid !== 1'b1) begin
          fails++;
          $display("FAIL %s stall: out_valid=%b while stalled, expected 1", name, out_valid);
        end
      end
      rdy = (cyc >= ready_hold) && (int'($urandom_range(99)) < ready_pct);
      if (cyc >= ready_hold && out_valid === 1'b1 && rdy_pat.size() > 0) rdy = rdy_pat.pop_front();
      out_ready = rdy;
      xf = (out_valid === 1'b1) && rdy;
      pv_stall = (out_valid === 1'b1) && !rdy;
      if (out_valid === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL %s head: out_valid with char %h, expected no pending char", name, out_char);
        end else if (out_char !== exp_q[0].ch || out_last !== exp_q[0].last || out_index !== exp_q[0].idx) begin
          fails++;
          $display("FAIL %s head: got char=%h last=%b idx=%0d, expected char=%h last=%b idx=%0d",
                   name, out_char, out_last, out_index, exp_q[0].ch, exp_q[0].last, exp_q[0].idx);
        end
      end
      match_valid = pv_xfer;
      match_in = pv_xfer && (pv_ch == match_ch);
      pv_xfer = xf;
      pv_ch = 8'h00;
      if (xf && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        pv_ch = e.ch;
        if (e.last) rt_q.push_back(cyc);
      end
      if (wpos < int'(sc_chars.size()) && int'($urandom_range(99)) < wr_pct) begin
        wr_en = 1'b1; wr_char = sc_chars[wpos]; wr_last = sc_last[wpos];
        if (occ < DEPTH) begin
          ne.ch = sc_chars[wpos]; ne.last = sc_last[wpos]; ne.idx = widx;
          exp_q.push_back(ne);
          if (!wfound && sc_chars[wpos] == match_ch) begin
            wfound = 1; wfidx = widx;
          end
          widx = widx + 8'd1;
          if (sc_last[wpos]) begin
            r.found = wfound; r.idx = wfidx;
            res_q.push_back(r);
            wfound = 0; wfidx = 0; widx = 0;
          end
          occ++;
        end else begin
          ovf = 1;
        end
        wpos++;
      end else begin
        wr_en = 1'b0; wr_char = 8'($urandom); wr_last = 1'($urandom);
      end
      if (xf) occ--;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (wpos == int'(sc_chars.size()) && exp_q.size() == 0 && res_q.size() == 0) idle++;
    end
    tests++;
    if (wpos != int'(sc_chars.size()) || exp_q.size() != 0 || res_q.size() != 0) begin
      fails++;
      $display("FAIL %s completion: %0d chars and %0d results pending after %0d cycles, expected 0",
               name, exp_q.size(), res_q.size(), cyc);
    end
    idle_inputs();
    sc_chars.delete(); sc_last.delete(); rdy_pat.delete();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({full, overflow, out_valid, out_last, result_valid, result_found} !== 6'b0) begin
      fails++;
      $display("FAIL reset flags: got full=%b ovf=%b valid=%b last=%b rv=%b rf=%b, expected all 0",
               full, overflow, out_valid, out_last, result_valid, result_found);
    end
    tests++;
    if (out_char !== 8'h00 || out_index !== 8'd0 || result_index !== 8'd0) begin
      fails++;
      $display("FAIL reset data: got char=%h idx=%0d ridx=%0d, expected 0", out_char, out_index, result_index);
    end
  endtask

  task automatic test_single_string();
    add_str("ABA");
    run_scenario("aba", 1, 100, 100, 0, 8'h41);
  endtask

  task automatic test_no_match();
    add_str("xyz");
    run_scenario("xyz", 1, 100, 100, 0, 8'h41);
  endtask

  task automatic test_backpressure();
    rdy_pat.push_back(1); rdy_pat.push_back(0); rdy_pat.push_back(0); rdy_pat.push_back(1);
    add_str("QRS");
    run_scenario("backpressure", 1, 100, 100, 0, 8'h52);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) begin
      sc_chars.push_back(8'h61 + 8'(i));
      sc_last.push_back(i == 15);
    end
    run_scenario("overflow", 1, 100, 100, 20, 8'h63);
  endtask

  task automatic test_back_to_back();
    add_str("AB");
    add_str("CA");
    run_scenario("back_to_back", 1, 100, 100, 0, 8'h41);
  endtask

  task automatic test_latency_throughput();
    logic [7:0] chs [4];
    logic [9:0] vexp;
    logic [9:0] rexp;
    chs[0] = 8'h61; chs[1] = 8'h62; chs[2] = 8'h63; chs[3] = 8'h64;
    vexp = 10'h03C;
    rexp = 10'h100;
    do_reset();
    out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      if (n > 0) begin
        tests++;
        if (out_valid !== vexp[n] || (vexp[n] && (out_index !== 8'(n - 2) || out_char !== chs[n - 2]))) begin
          fails++;
          $display("FAIL latency step %0d: got valid=%b idx=%0d char=%h, expected valid=%b",
                   n, out_valid, out_index, out_char, vexp[n]);
        end
        tests++;
        if (result_valid !== rexp[n] || (rexp[n] && (result_found !== 1'b0 || result_index !== 8'd0))) begin
          fails++;
          $display("FAIL latency result step %0d: got rv=%b rf=%b ridx=%0d, expected rv=%b rf=0 ridx=0",
                   n, result_valid, result_found, result_index, rexp[n]);
        end
      end
      if (n < 4) begin
        wr_en = 1'b1; wr_char = chs[n]; wr_last = (n == 3);
      end else begin
        wr_en = 1'b0; wr_last = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_stream();
    bit hit, pv;
    int n;
    do_reset();
    add_str("HELLO");
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_char = sc_chars[i]; wr_last = sc_last[i];
      @(posedge clk);
      @(negedge clk);
    end
    wr_en = 1'b0; wr_last = 1'b0;
    sc_chars.delete(); sc_last.delete();
    hit = 0; pv = 0; n = 0;
    while (!hit && n < 20) begin
      out_ready = 1'b1; match_valid = pv; match_in = pv;
      pv = (out_valid === 1'b1);
      hit = pv && (out_index === 8'd2);
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL reset_mid reach: index 2 not transferred within %0d cycles", n);
    end
    reset = 1'b1; out_ready = 1'b0; match_valid = 1'b1; match_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if ({full, overflow, out_valid, out_char, out_last, out_index, result_valid, result_found, result_index} !== '0) begin
      fails++;
      $display("FAIL reset_mid outputs: got full=%b ovf=%b valid=%b char=%h last=%b idx=%0d rv=%b rf=%b ridx=%0d, expected all 0",
               full, overflow, out_valid, out_char, out_last, out_index, result_valid, result_found, result_index);
    end
    reset = 1'b0; match_valid = 1'b0; match_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (result_valid !== 1'b0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid quiet: got rv=%b valid=%b, expected 0 0", result_valid, out_valid);
      end
    end
    add_str("NEW");
    run_scenario("after_reset", 0, 100, 100, 0, 8'h5A);
  endtask

  task automatic test_index_wrap();
    for (int i = 0; i < 258; i++) begin
      sc_chars.push_back(i == 257 ? 8'h5A : 8'h61);
      sc_last.push_back(i == 257);
    end
    run_scenario("index_wrap", 1, 100, 100, 0, 8'h5A);
  endtask

  task automatic test_random();
    int nstr, len;
    for (int it = 0; it < 8; it++) begin
      nstr = int'($urandom_range(3, 1));
      for (int s = 0; s < nstr; s++) begin
        len = int'($urandom_range(7, 1));
        for (int k = 0; k < len; k++) begin
          sc_chars.push_back(8'h41 + 8'($urandom_range(3)));
          sc_last.push_back(k == len - 1);
        end
      end
      run_scenario("random", 1, 40 + int'($urandom_range(60)), 50 + int'($urandom_range(50)),
                   int'($urandom_range(25)), 8'h41 + 8'($urandom_range(3)));
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_string();
    test_no_match();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_latency_throughput();
    test_reset_mid_stream();
    test_index_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
